// File: rtl/pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared types and constants for the program-counter / next-PC stage of the
// 8-bit single-cycle core.
//   PC_W       : PC width; the instruction address space is 2**PC_W words.
//   LUT_AW     : branch-LUT index width; the LUT has 2**LUT_AW entries.
//   pc_t       : program-counter word.
//   lut_idx_t  : branch-LUT index taken from the instruction.
//   pc_state_t : sequencer state (IDLE / RUN / HALT).
// ----------------------------------------------------------------------------
package pc_sequencer_pkg;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 5;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [LUT_AW-1:0] lut_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Highest fetch address; stepping past it rolls the PC over to 0.
  localparam pc_t PC_MAX = '1;

  // Sequential step, naturally modulo 2**PC_W because of the result width.
  function automatic pc_t pc_incr(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

  // True when a sequential step from this PC wraps back to address 0.
  function automatic logic pc_wraps(input pc_t pc);
    return (pc == PC_MAX);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Bundle between the decode/execute side of the core and the PC sequencer.
//   start, start_addr : program launch request and first address.
//   stall             : memory wait, freezes the sequencer for a cycle.
//   halt, branch_en   : decoded halt / bne at the current PC.
//   alu_zero          : ALU zero flag (1 = bne taken).
//   target_idx        : branch-LUT index from the instruction.
//   pc                : registered fetch address.
//   fetch_valid       : high while running.
//   done              : high while halted.
//   wrap_err          : sticky PC rollover indication.
// Modports: master = core side (drives controls), slave = sequencer.
// ----------------------------------------------------------------------------
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic     start;
  pc_t      start_addr;
  logic     stall;
  logic     halt;
  logic     branch_en;
  logic     alu_zero;
  lut_idx_t target_idx;
  pc_t      pc;
  logic     fetch_valid;
  logic     done;
  logic     wrap_err;

  modport master (
    output start, start_addr, stall, halt, branch_en, alu_zero, target_idx,
    input  pc, fetch_valid, done, wrap_err
  );

  modport slave (
    input  start, start_addr, stall, halt, branch_en, alu_zero, target_idx,
    output pc, fetch_valid, done, wrap_err
  );

endinterface

// File: rtl/pc_sequencer_branch_lut.sv
// ----------------------------------------------------------------------------
// branch_lut
// Constant ROM of absolute branch targets for the loaded program. This is the
// one place to edit branch addresses; any index not listed returns 0.
//   i_target_idx : LUT index from the instruction.
//   o_target     : absolute branch target address.
// ----------------------------------------------------------------------------
module branch_lut
  import pc_sequencer_pkg::*;
(
  input  lut_idx_t i_target_idx,
  output pc_t      o_target
);

  always_comb begin
    o_target = '0;
    case (i_target_idx)
      lut_idx_t'(1):  o_target = pc_t'(50);
      lut_idx_t'(3):  o_target = pc_t'(200);
      lut_idx_t'(9):  o_target = pc_t'(1023);
      lut_idx_t'(31): o_target = pc_t'(5);
      default:        o_target = '0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Program counter and run/halt sequencing for the single-cycle core. Provides
// the fetch address each cycle and resolves bne from the ALU zero flag in the
// same cycle; the new PC appears one clock later, with no delay slot.
//   clk   : system clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : pc_sequencer_if.slave (controls in, pc/status out).
// ----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  pc_state_t r_state;
  pc_t       r_pc;
  logic      r_fetch_valid;
  logic      r_done;
  logic      r_wrap_err;

  pc_state_t w_state_nxt;
  pc_t       w_pc_nxt;
  pc_t       w_target;
  logic      w_wrap_set;
  logic      w_wrap_clr;

  branch_lut u_branch_lut (
    .i_target_idx (bus.target_idx),
    .o_target     (w_target)
  );

  // Next-PC / next-state mux. In RUN: stall > halt > taken bne > pc+1.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_wrap_set  = 1'b0;
    w_wrap_clr  = 1'b0;
    case (r_state)
      IDLE, HALT: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = bus.start_addr;
          w_wrap_clr  = 1'b1;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          if (bus.halt) begin
            w_state_nxt = HALT;
          end else if (bus.branch_en && bus.alu_zero) begin
            // Absolute target: never counts as a rollover, even from PC_MAX.
            w_pc_nxt = w_target;
          end else begin
            w_pc_nxt   = pc_incr(r_pc);
            w_wrap_set = pc_wraps(r_pc);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; status flags are registered from the next state so they
  // carry no combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fetch_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_valid <= (w_state_nxt == RUN);
      r_done        <= (w_state_nxt == HALT);
    end
  end

  // PC and sticky wrap flag; a fresh program launch clears the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_wrap_err <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_wrap_clr) begin
        r_wrap_err <= 1'b0;
      end else if (w_wrap_set) begin
        r_wrap_err <= 1'b1;
      end
    end
  end

  assign bus.pc          = r_pc;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.done        = r_done;
  assign bus.wrap_err    = r_wrap_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer with a behavioural reference model and
// literal checkpoints.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic clk;
  logic rst_n;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference program table for the branch targets.
  int lut_m [32];
  initial begin
    for (int i = 0; i < 32; i++) lut_m[i] = 0;
    lut_m[1]  = 50;
    lut_m[3]  = 200;
    lut_m[9]  = 1023;
    lut_m[31] = 5;
  end

  // Behavioural model: 0 = idle, 1 = running, 2 = halted.
  int m_st;
  int m_pc;
  bit m_we;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0;
      m_pc <= 0;
      m_we <= 1'b0;
    end else if (m_st != 1) begin
      if (bus.start) begin
        m_st <= 1;
        m_pc <= int'(bus.start_addr);
        m_we <= 1'b0;
      end
    end else if (!bus.stall) begin
      if (bus.halt) m_st <= 2;
      else if (bus.branch_en && bus.alu_zero) m_pc <= lut_m[bus.target_idx];
      else begin
        m_pc <= (m_pc + 1) % 1024;
        if (m_pc + 1 == 1024) m_we <= 1'b1;
      end
    end
  end

  // Literal checkpoint requested by the stimulus, checked on the next negedge.
  bit    lit_en;
  string lit_name;
  int    lit_pc;
  bit    lit_fv, lit_dn, lit_we;

  int n_cmp;
  int n_err;

  initial begin
    n_cmp = 0;
    n_err = 0;
    forever begin
      @(negedge clk);
      n_cmp++;
      if (int'(bus.pc) != m_pc || bus.fetch_valid !== logic'(m_st == 1) ||
          bus.done !== logic'(m_st == 2) || bus.wrap_err !== logic'(m_we)) begin
        n_err++;
        $display("FAIL model t=%0t: got pc=%0d fv=%b done=%b we=%b, need pc=%0d fv=%b done=%b we=%b",
                 $time, bus.pc, bus.fetch_valid, bus.done, bus.wrap_err,
                 m_pc, (m_st == 1), (m_st == 2), m_we);
      end
      if (lit_en) begin
        n_cmp++;
        if (int'(bus.pc) != lit_pc || bus.fetch_valid !== logic'(lit_fv) ||
            bus.done !== logic'(lit_dn) || bus.wrap_err !== logic'(lit_we)) begin
          n_err++;
          $display("FAIL %s t=%0t: got pc=%0d fv=%b done=%b we=%b, need pc=%0d fv=%b done=%b we=%b",
                   lit_name, $time, bus.pc, bus.fetch_valid, bus.done, bus.wrap_err,
                   lit_pc, lit_fv, lit_dn, lit_we);
        end
      end
    end
  end

  task automatic drv(input bit st, input int addr, input bit stl, input bit hlt,
                     input bit br, input bit az, input int idx);
    bus.start      = st;
    bus.start_addr = 10'(addr);
    bus.stall      = stl;
    bus.halt       = hlt;
    bus.branch_en  = br;
    bus.alu_zero   = az;
    bus.target_idx = 5'(idx);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic step_chk(input string nm, input int p, input bit fv,
                          input bit dn, input bit we);
    lit_name = nm;
    lit_pc   = p;
    lit_fv   = fv;
    lit_dn   = dn;
    lit_we   = we;
    lit_en   = 1'b1;
    step();
  endtask

  initial begin
    lit_en = 1'b0;
    rst_n  = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    step_chk("reset_state", 0, 0, 0, 0);
    rst_n = 1'b1;
    step_chk("idle_hold", 0, 0, 0, 0);

    // Launch and sequential fetch.
    drv(1, 100, 0, 0, 0, 0, 0);
    step_chk("start_load", 100, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step_chk("seq", 100 + i, 1, 0, 0);

    // Branch taken / not taken / unprogrammed entry.
    drv(0, 0, 0, 0, 1, 1, 3);
    step_chk("bne_taken", 200, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 3);
    step_chk("bne_not_taken", 201, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 1, 4);
    step_chk("bne_unprog", 0, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 1, 1);
    step_chk("bne_to_50", 50, 1, 0, 0);

    // Priority: stall over halt over branch.
    drv(0, 0, 1, 1, 1, 1, 3);
    step_chk("stall_prio", 50, 1, 0, 0);
    drv(0, 0, 0, 1, 1, 1, 3);
    step_chk("halt_prio", 50, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    step_chk("halt_hold", 50, 0, 1, 0);

    // Restart from HALT, then start ignored in RUN.
    drv(1, 7, 0, 0, 0, 0, 0);
    step_chk("restart_7", 7, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    step_chk("at_10", 10, 1, 0, 0);
    drv(1, 500, 0, 0, 0, 0, 0);
    step_chk("start_ignored", 11, 1, 0, 0);

    // Wrap.
    drv(0, 0, 0, 1, 0, 0, 0);
    step_chk("halt_11", 11, 0, 1, 0);
    drv(1, 1022, 0, 0, 0, 0, 0);
    step_chk("wrap_load", 1022, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    step_chk("wrap_1023", 1023, 1, 0, 0);
    step_chk("wrap_0", 0, 1, 0, 1);
    step_chk("wrap_1", 1, 1, 0, 1);
    drv(0, 0, 0, 0, 1, 1, 9);
    step_chk("bne_to_max", 1023, 1, 0, 1);
    drv(0, 0, 0, 1, 0, 0, 0);
    step_chk("halt_sticky", 1023, 0, 1, 1);
    drv(1, 20, 0, 0, 0, 0, 0);
    step_chk("restart_clr", 20, 1, 0, 0);

    // Branch out of PC_MAX never flags a wrap.
    drv(0, 0, 0, 0, 1, 1, 9);
    step_chk("bne_max_a", 1023, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 1, 31);
    step_chk("bne_max_b", 5, 1, 0, 0);

    // Asynchronous reset mid-RUN at pc=37.
    drv(0, 0, 0, 1, 0, 0, 0);
    step();
    drv(1, 35, 0, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0);
    step();
    step_chk("at_37", 37, 1, 0, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    lit_name = "async_reset";
    lit_pc   = 0;
    lit_fv   = 1'b0;
    lit_dn   = 1'b0;
    lit_we   = 1'b0;
    lit_en   = 1'b1;
    @(negedge clk);
    #1;
    lit_en = 1'b0;
    step();
    rst_n = 1'b1;
    step_chk("post_reset_idle", 0, 0, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
